// File: rtl/serial_cmp_pkg.sv
// Shared types and sizes for the bit-serial magnitude comparator.
// Holds the FSM state enum, running-result enum and per-bit step rule.
package serial_cmp_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ,
        RES_GT,
        RES_LT
    } res_t;

    // One LSB-first step: a differing pair overrides the running result.
    // With msb_sgn set the pair is a sign bit, so the sense is inverted.
    function automatic res_t bit_step(
        input res_t cur,
        input logic a,
        input logic b,
        input logic msb_sgn
    );
        res_t r;
        r = cur;
        if (a != b) begin
            if (a ^ msb_sgn)
                r = RES_GT;
            else
                r = RES_LT;
        end
        return r;
    endfunction

endpackage

// File: rtl/shreg32.sv
// Parallel-load, LSB-out shift register; load has priority over shift.
// Ports: clk, rst (async low), load, shift, d[WIDTH-1:0] -> q_lsb.
import serial_cmp_pkg::*;

module shreg32 (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_lsb
);

    logic [WIDTH-1:0] r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r <= '0;
        else if (load)
            r <= d;
        else if (shift)
            r <= {1'b0, r[WIDTH-1:1]};
    end

    assign q_lsb = r[0];

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial 32-bit comparator: IDLE->LOAD->SHIFT(32)->DONE, LSB first.
// Ports: clk, rst (async low), start, A, B -> busy, done, gt, eq, lt.
// Define SERIAL_CMP_SIGNED_EN for two's-complement comparison.
import serial_cmp_pkg::*;

module serial_cmp_ctrl (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    res_t             res;
    res_t             res_step;
    logic             ld;
    logic             sh;
    logic             a_bit;
    logic             b_bit;
    logic             sgn_bit;

    shreg32 u_sra (
        .clk   (clk),
        .rst   (rst),
        .load  (ld),
        .shift (sh),
        .d     (A),
        .q_lsb (a_bit)
    );

    shreg32 u_srb (
        .clk   (clk),
        .rst   (rst),
        .load  (ld),
        .shift (sh),
        .d     (B),
        .q_lsb (b_bit)
    );

`ifdef SERIAL_CMP_SIGNED_EN
    assign sgn_bit = (cnt == LAST);
`else
    assign sgn_bit = 1'b0;
`endif

    assign res_step = bit_step(res, a_bit, b_bit, sgn_bit);

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        sh        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = LOAD;
            end
            LOAD: begin
                ld        = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                sh = 1'b1;
                if (cnt == LAST)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result flags are loaded from the final step so they are
    // already valid in the cycle that done is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            res   <= RES_EQ;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == LOAD) begin
                cnt <= '0;
                res <= RES_EQ;
            end else if (state == SHIFT) begin
                cnt <= cnt + 1'b1;
                res <= res_step;
                if (cnt == LAST) begin
                    gt <= (res_step == RES_GT);
                    eq <= (res_step == RES_EQ);
                    lt <= (res_step == RES_LT);
                end
            end
        end
    end

    assign busy = (state == LOAD) || (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: doc/serial_cmp_ctrl.md
SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start  input  1  request to compare A and B, sampled in IDLE only.
REQ-004 SHALL have port A  input  32  operand A, captured on accepted start.
REQ-005 SHALL have port B  input  32  operand B, captured on accepted start.
REQ-006 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-007 SHALL have port done  output  1  single-cycle pulse when the result becomes valid.
REQ-008 SHALL have ports gt, eq, lt  output  1 each  comparison result, one-hot once valid.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE; reset state IDLE.
REQ-010 SHALL move IDLE->LOAD when start=1; A and B are parallel-loaded into two 32-bit shift registers in LOAD.
REQ-011 SHALL move LOAD->SHIFT after one cycle, clearing the 5-bit bit counter to 0 and the running result to "equal".
REQ-012 SHALL in SHIFT shift both registers one bit per cycle, LSB first, and process the shifted-out bit pair a_i, b_i.
REQ-013 SHALL per bit: if a_i!=b_i, set running result to gt when a_i=1, lt when b_i=1; if equal, keep the running result (later bit overrides, so the MSB decides).
REQ-014 SHALL stay in SHIFT exactly 32 cycles; counter wraps 31->0 on the SHIFT->DONE transition.
REQ-015 SHALL in DONE assert done for one cycle, update gt/eq/lt from the running result, then return to IDLE.
REQ-016 SHALL hold gt/eq/lt stable from DONE until the next DONE; total latency from start sample to done = 34 cycles.
REQ-017 SHALL ignore start while busy; start held high in IDLE after DONE begins a new compare on the next cycle.
REQ-018 SHALL keep busy=1 in LOAD and SHIFT, busy=0 in IDLE and DONE.
REQ-019 SHALL not change A/B registers if the A/B ports change after LOAD.

Reset
REQ-020 SHALL on rst=0, at any time including mid-SHIFT, force IDLE, counter 0, both shift registers 0, busy=0, done=0, gt=0, eq=0, lt=0.
REQ-021 SHALL not assert done for any operation aborted by reset.

Configuration
REQ-022 SHALL, with SERIAL_CMP_SIGNED_EN defined, treat operands as two's complement: at bit 31 a differing pair sets gt when b_31=1, lt when a_31=1.
REQ-023 SHALL, without SERIAL_CMP_SIGNED_EN, compare unsigned per REQ-013 for all bits.

Structure
REQ-024 SHALL place the state enum typedef, WIDTH=32 and CNT_W=5 in shared package serial_cmp_pkg.
REQ-025 SHALL instantiate sub-module shreg32 twice (32-bit parallel-load, LSB-out shift register with load and shift enables, same clk/rst).

Verification
REQ-026 SHALL check A=32'h0000_0FFF, B=32'h0000_0FFE, start 1 cycle -> done 34 cycles later, gt=1 eq=0 lt=0.
REQ-027 SHALL check A=B=32'hDEAD_BEEF -> eq=1 at done; busy high exactly 33 cycles.
REQ-028 SHALL check A=32'h8000_0000, B=32'h0000_0001 -> gt=1 without SERIAL_CMP_SIGNED_EN, lt=1 with it.
REQ-029 SHALL check rst=0 pulse at SHIFT cycle 10 -> all outputs 0 immediately, no done pulse, next start compares correctly.
REQ-030 SHALL check start pulsed again during SHIFT with new A/B -> ignored; result reflects first operands only.
